ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//  Parametrised multi-cycle control FSM for the arithmetic processor datapath. Accepts one 16-bit
//  instruction via valid/ready, sequences it, and drives A/G/bus enables plus one-hot reg/tri strobes.
//  Adds a SUMALL instruction that sums R0..R(NREGS-1) with an internal loop counter.
//  No X outputs. Sits between the program counter/instruction ROM and the datapath.
// PARAMETERS
//  NREGS    16  number of GP registers, 2..16; sets reg_en/tri_en width
//  IDX_W    4   register index field width; must be >= clog2(NREGS)
//  SEL_W    3   ALU select width
// PORTS
//  clk          in   1          rising-edge clock
//  reset        in   1          synchronous, active-high reset
//  instr_valid  in   1          instruction available
//  instr        in   16         [15:12] opcode, [11:8] rx, [7:4] ry
//  instr_ready  out  1          high only in IDLE; accept = valid & ready
//  aen          out  1          load A register
//  gen          out  1          load G register
//  gout         out  1          G drives bus
//  sel          out  SEL_W      ALU op: 0 add, 1 xor, 2 sub, 3 mul, 4 div, 5 ones
//  extern_en    out  1          external data drives bus
//  read_addr    out  1          external bus carries PC address (LDPC)
//  reg_en       out  NREGS      one-hot register load strobe
//  tri_en       out  NREGS      one-hot register tri-state bus drive
//  pc_inc       out  1          one-cycle pulse: instruction complete, PC+1
//  pc_load      out  1          one-cycle pulse: branch, PC <= bus
//  busy         out  1          ~IDLE
// BEHAVIOUR
//  - Instruction latched into internal IR on accept; instr ignored otherwise.
//  - Outputs: combinational decode of registered state + IR; unused strobes/sel are 0 (never X).
//  - reset: state=IDLE, count=1, IR=0; all outputs 0 except instr_ready=1.
//  - Reset mid-operation aborts; no pc_inc/pc_load for the aborted instruction.
//  - Opcodes, one state per line, 1 cycle each:
//    0 LOAD : EX: extern_en, reg_en[rx], pc_inc
//    1 MOVE : EX: tri_en[ry], reg_en[rx], pc_inc
//    2 LDPC : EX: extern_en, read_addr, reg_en[rx], pc_inc
//    3 BR   : EX: tri_en[rx], pc_load (no pc_inc)
//    4-8 ALU: A1: aen, tri_en[rx] -> A2: gen, sel, tri_en[ry] -> A3: gout, reg_en[rx], pc_inc
//    9 ONES : A1: aen, tri_en[rx] -> A2: gen, sel=5, tri_en[rx] -> A3: gout, reg_en[0], pc_inc
//    A SUMALL: S0: aen, tri_en[0] -> S1: gen, sel=0, tri_en[count]
//             -> S2: gout, aen; if count==NREGS-1 go S3 else count++ and go S1
//             -> S3: gout, reg_en[rx], pc_inc; count reset to 1
//  - Latency (accept to pc_inc): 1-cycle ops 1; ALU/ONES 3; SUMALL 2*(NREGS-1)+2.
//  - Every state except the last of an instruction goes unconditionally to its successor; last -> IDLE.
//  - rx/ry >= NREGS: the affected strobe stays 0; instruction still completes normally.
//  - count width = IDX_W; never wraps (bounded by NREGS-1).
//  - New instruction accepted in the cycle after pc_inc/pc_load (IDLE); no overlap.
// CONFIGURATION
//  CTRL_SEQ_TRAP_EN defined: opcodes B-F go to HALT: all outputs 0, instr_ready=0, busy=1,
//    until reset.
//  Not defined: opcodes B-F execute as NOP: one EX cycle with only pc_inc.
// TESTING
//  1 reset held 3 cycles mid-ALU -> next cycle all outputs 0, instr_ready=1, no pc_inc.
//  2 instr=16'h4230 (ADD R2,R3) -> A1 aen,tri_en=0x0004; A2 gen,sel=0,tri_en=0x0008;
//    A3 gout,reg_en=0x0004,pc_inc.
//  3 instr=16'h3500 (BR R5) -> tri_en=0x0020, pc_load=1, pc_inc=0; then instr_ready=1.
//  4 NREGS=16, instr=16'hA700 (SUMALL R7) -> 15 S1/S2 pairs with tri_en 0x0002..0x8000;
//    S3 reg_en=0x0080; pc_inc exactly 32 cycles after accept.
//  5 instr_valid held high with instr=16'h0100, then 16'h1120 -> LOAD R1 and MOVE R1,R2
//    accepted back-to-back, 2-cycle spacing.
//  6 instr=16'hF000: TRAP_EN -> HALT, busy=1 until reset; else single pc_inc, no other strobe.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer: decodes one 16-bit instruction into datapath strobes (optional CTRL_SEQ_TRAP_EN: B-F halt).
// Latency accept->pc_inc: 1 for LOAD/MOVE/LDPC/NOP, 3 for ALU/ONES, 2*(NREGS-1)+2 for SUMALL.
// Backpressure: instr_ready only in IDLE; one instruction in flight, next accepted the cycle after completion.
module ctrl_sequencer #(
    parameter int NREGS = 16,
    parameter int IDX_W = 4,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [15:0]      instr,
    output logic             instr_ready,
    output logic             aen,
    output logic             gen,
    output logic             gout,
    output logic [SEL_W-1:0] sel,
    output logic             extern_en,
    output logic             read_addr,
    output logic [NREGS-1:0] reg_en,
    output logic [NREGS-1:0] tri_en,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             busy
);

    typedef enum logic [3:0] {
        IDLE, EX, A1, A2, A3, S0, S1, S2, S3, HALT
    } state_t;

    state_t           state;
    logic [11:0]      ir;
    logic [IDX_W-1:0] count;
    logic [3:0]       op;
    logic [3:0]       rx;
    logic [3:0]       ry;
    logic             unused_instr;

    assign op = ir[11:8];
    assign rx = ir[7:4];
    assign ry = ir[3:0];
    assign unused_instr = ^instr[3:0];

    // Out-of-range indices produce an all-zero strobe.
    function automatic logic [NREGS-1:0] onehot(input int idx);
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            v[i] = (idx == i);
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= IDX_W'(1);
            ir    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        ir <= instr[15:4];
                        if (instr[15:12] <= 4'h3) begin
                            state <= EX;
                        end else if (instr[15:12] <= 4'h9) begin
                            state <= A1;
                        end else if (instr[15:12] == 4'hA) begin
                            state <= S0;
                        end else begin
`ifdef CTRL_SEQ_TRAP_EN
                            state <= HALT;
`else
                            state <= EX;
`endif
                        end
                    end
                end
                EX:   state <= IDLE;
                A1:   state <= A2;
                A2:   state <= A3;
                A3:   state <= IDLE;
                S0:   state <= S1;
                S1:   state <= S2;
                S2: begin
                    if (count == IDX_W'(NREGS - 1)) begin
                        state <= S3;
                    end else begin
                        count <= count + IDX_W'(1);
                        state <= S1;
                    end
                end
                S3: begin
                    count <= IDX_W'(1);
                    state <= IDLE;
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        instr_ready = (state == IDLE);
        busy        = (state != IDLE);
        aen         = 1'b0;
        gen         = 1'b0;
        gout        = 1'b0;
        sel         = '0;
        extern_en   = 1'b0;
        read_addr   = 1'b0;
        reg_en      = '0;
        tri_en      = '0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        case (state)
            EX: begin
                case (op)
                    4'h0: begin
                        extern_en = 1'b1;
                        reg_en    = onehot(int'(rx));
                        pc_inc    = 1'b1;
                    end
                    4'h1: begin
                        tri_en = onehot(int'(ry));
                        reg_en = onehot(int'(rx));
                        pc_inc = 1'b1;
                    end
                    4'h2: begin
                        extern_en = 1'b1;
                        read_addr = 1'b1;
                        reg_en    = onehot(int'(rx));
                        pc_inc    = 1'b1;
                    end
                    4'h3: begin
                        tri_en  = onehot(int'(rx));
                        pc_load = 1'b1;
                    end
                    default: pc_inc = 1'b1;
                endcase
            end
            A1: begin
                aen    = 1'b1;
                tri_en = onehot(int'(rx));
            end
            A2: begin
                gen = 1'b1;
                // ONES reduces rx on its own; the other ALU ops combine rx with ry.
                if (op == 4'h9) begin
                    sel    = SEL_W'(5);
                    tri_en = onehot(int'(rx));
                end else begin
                    sel    = SEL_W'(op - 4'h4);
                    tri_en = onehot(int'(ry));
                end
            end
            A3: begin
                gout   = 1'b1;
                reg_en = (op == 4'h9) ? onehot(0) : onehot(int'(rx));
                pc_inc = 1'b1;
            end
            S0: begin
                aen    = 1'b1;
                tri_en = onehot(0);
            end
            S1: begin
                gen    = 1'b1;
                tri_en = onehot(int'(count));
            end
            S2: begin
                gout = 1'b1;
                aen  = 1'b1;
            end
            S3: begin
                gout   = 1'b1;
                reg_en = onehot(int'(rx));
                pc_inc = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Randomized and directed bench for ctrl_sequencer with a per-cycle expected-output queue model.
module tb_ctrl_sequencer;

    localparam int NREGS = 16;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready, aen, gen, gout, extern_en, read_addr, pc_inc, pc_load, busy;
    logic [2:0]  sel;
    logic [15:0] reg_en, tri_en;

    ctrl_sequencer #(.NREGS(NREGS), .IDX_W(4), .SEL_W(3)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .aen(aen), .gen(gen), .gout(gout), .sel(sel),
        .extern_en(extern_en), .read_addr(read_addr), .reg_en(reg_en), .tri_en(tri_en),
        .pc_inc(pc_inc), .pc_load(pc_load), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rdy, aen, gen, gout;
        logic [2:0]  sel;
        logic        ext, rda;
        logic [15:0] ren, ten;
        logic        inc, ld, busy;
    } ov_t;

    int   n_cmp = 0;
    int   n_err = 0;
    ov_t  q[$];
    ov_t  exp_v;
    bit   halted = 0;
    bit   started = 0;

    function automatic ov_t idle_v();
        ov_t v = '0;
        v.rdy = 1'b1;
        return v;
    endfunction

    function automatic ov_t busy_v();
        ov_t v = '0;
        v.busy = 1'b1;
        return v;
    endfunction

    function automatic logic [15:0] oh(input int x);
        return (x < NREGS) ? (16'd1 << x) : 16'd0;
    endfunction

    // Expands one instruction into the list of output vectors it must produce, one per cycle.
    function automatic void expand(input logic [15:0] ins);
        int  op, rx, ry;
        ov_t v;
        op = int'(ins[15:12]);
        rx = int'(ins[11:8]);
        ry = int'(ins[7:4]);
        if (op <= 3) begin
            v = busy_v();
            if (op == 3) begin
                v.ten = oh(rx);
                v.ld  = 1'b1;
            end else begin
                v.ren = oh(rx);
                v.inc = 1'b1;
                v.ext = (op != 1);
                v.rda = (op == 2);
                if (op == 1) v.ten = oh(ry);
            end
            q.push_back(v);
        end else if (op <= 9) begin
            v = busy_v(); v.aen = 1'b1; v.ten = oh(rx); q.push_back(v);
            v = busy_v(); v.gen = 1'b1;
            v.sel = (op == 9) ? 3'd5 : 3'(op - 4);
            v.ten = oh((op == 9) ? rx : ry);
            q.push_back(v);
            v = busy_v(); v.gout = 1'b1; v.ren = oh((op == 9) ? 0 : rx); v.inc = 1'b1; q.push_back(v);
        end else if (op == 10) begin
            v = busy_v(); v.aen = 1'b1; v.ten = oh(0); q.push_back(v);
            for (int k = 1; k < NREGS; k++) begin
                v = busy_v(); v.gen = 1'b1; v.ten = oh(k); q.push_back(v);
                v = busy_v(); v.gout = 1'b1; v.aen = 1'b1; q.push_back(v);
            end
            v = busy_v(); v.gout = 1'b1; v.ren = oh(rx); v.inc = 1'b1; q.push_back(v);
        end else begin
`ifdef CTRL_SEQ_TRAP_EN
            halted = 1;
`else
            v = busy_v(); v.inc = 1'b1; q.push_back(v);
`endif
        end
    endfunction

    initial exp_v = idle_v();

    // Model advances on the clock edge using the inputs the DUT sees on that edge.
    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            halted  = 0;
            exp_v   = idle_v();
            started = 1;
        end else begin
            if (exp_v.rdy && instr_valid) expand(instr);
            if (q.size() > 0)  exp_v = q.pop_front();
            else if (halted)   exp_v = busy_v();
            else               exp_v = idle_v();
        end
    end

    always @(negedge clk) begin : cmp
        ov_t d;
        if (started) begin
            d = '{instr_ready, aen, gen, gout, sel, extern_en, read_addr,
                  reg_en, tri_en, pc_inc, pc_load, busy};
            n_cmp++;
            if (d !== exp_v) begin
                n_err++;
                $display("FAIL cycle_check t=%0t dut=%h model=%h", $time, d, exp_v);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 32'(instr_ready), 32'd1);
    endtask

    // Returns at the negedge showing the first execution cycle of the instruction.
    task automatic send(input logic [15:0] ins);
        wait_idle();
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'($urandom);
    endtask

    initial begin : stim
        int          k, lat;
        logic [15:0] t2, t30, r32;
        logic [3:0]  op;

        reset = 1'b1; instr_valid = 1'b0; instr = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);

        // Reset in the middle of an ALU op aborts it without completion pulses.
        send(16'h5230);
        chk("abort_a1_aen", 32'(aen), 32'd1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 32'(instr_ready), 32'd1);
        chk("abort_strobes", {reg_en, tri_en}, 32'd0);
        @(negedge clk);
        chk("abort_no_inc", {30'd0, pc_inc, busy}, 32'd0);

        send(16'h4230);
        chk("add_a1", {15'd0, aen, tri_en}, {15'd0, 1'b1, 16'h0004});
        @(negedge clk);
        chk("add_a2", {12'd0, gen, sel, tri_en}, {12'd0, 1'b1, 3'd0, 16'h0008});
        @(negedge clk);
        chk("add_a3", {14'd0, gout, pc_inc, reg_en}, {14'd0, 2'b11, 16'h0004});

        send(16'h3500);
        chk("br_ex", {14'd0, pc_load, pc_inc, tri_en}, {14'd0, 2'b10, 16'h0020});
        @(negedge clk);
        chk("br_ready_after", 32'(instr_ready), 32'd1);

        send(16'hA700);
        k = 1; lat = 0; t2 = '0; t30 = '0; r32 = '0;
        while (lat == 0 && k < 100) begin
            if (k == 2)  t2  = tri_en;
            if (k == 30) t30 = tri_en;
            if (pc_inc === 1'b1) begin
                lat = k;
                r32 = reg_en;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        chk("sumall_latency", 32'(lat), 32'd32);
        chk("sumall_first_s1", 32'(t2), 32'h0002);
        chk("sumall_last_s1", 32'(t30), 32'h8000);
        chk("sumall_s3_reg", 32'(r32), 32'h0080);

        wait_idle();
        instr = 16'h0100; instr_valid = 1'b1;
        @(negedge clk);
        chk("b2b_load", {14'd0, extern_en, pc_inc, reg_en}, {14'd0, 2'b11, 16'h0002});
        instr = 16'h1120;
        @(negedge clk);
        chk("b2b_gap_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("b2b_move", {tri_en, reg_en}, {16'h0004, 16'h0002});

`ifdef CTRL_SEQ_TRAP_EN
        send(16'hF000);
        chk("trap_halt", {29'd0, busy, instr_ready, pc_inc}, {29'd0, 3'b100});
        repeat (5) @(negedge clk);
        chk("trap_stays", {30'd0, busy, instr_ready}, {30'd0, 2'b10});
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`else
        send(16'hF000);
        chk("nop_inc", {31'd0, pc_inc}, 32'd1);
        chk("nop_quiet", {reg_en, tri_en}, 32'd0);
        chk("nop_ctrl", {27'd0, aen, gen, gout, extern_en, pc_load}, 32'd0);
        @(negedge clk);
        chk("nop_ready_after", 32'(instr_ready), 32'd1);
`endif

        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            instr_valid = ($urandom_range(0, 9) < 7);
            op          = 4'($urandom_range(0, 11));
            if (op == 4'd11) op = 4'($urandom_range(11, 15));
            instr = {op, 12'($urandom)};
            @(negedge clk);
        end
        reset = 1'b0; instr_valid = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
